// File: rtl/step_cmd_if.sv
// Command/strobe bundle between the UART RX path, step_cmd_sequencer and moverMotor.
// The host drives RX_DATA/RX_VALID; the sequencer drives the strobe and status lines.
interface step_cmd_if;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       STB;
  logic       DIR;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  modport master (
    output RX_DATA, RX_VALID,
    input  STB, DIR, BUSY, DONE, ERR
  );

  modport slave (
    input  RX_DATA, RX_VALID,
    output STB, DIR, BUSY, DONE, ERR
  );
endinterface

// File: rtl/step_cmd_sequencer.sv
// Turns one-byte motion commands into evenly paced STB bursts with a one-deep pending slot.
// Optional CMD_ABORT_EN: a byte with bit6=1 and count 0 aborts the running burst.
module step_cmd_sequencer #(
  parameter int unsigned STEP_DIV = 50000,
  parameter int unsigned STB_HIGH = 25000
) (
  input  logic      CLK,
  input  logic      RST,
  step_cmd_if.slave cmd
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, FIN} state_t;

  localparam logic [19:0] HIGH_LAST   = 20'(STB_HIGH - 1);
  localparam logic [19:0] PERIOD_LAST = 20'(STEP_DIV - 1);

  state_t      state_q;
  logic [19:0] phase_q;
  logic [5:0]  remaining_q;
  logic        dir_q;
  logic        stb_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        pend_valid_q;
  logic        pend_dir_q;
  logic [5:0]  pend_count_q;

  logic [5:0]  rx_count;
  logic        rx_cmd;
  logic        rx_abort;

  assign rx_count = cmd.RX_DATA[5:0];
  assign rx_cmd   = cmd.RX_VALID && (rx_count != 6'd0);

`ifdef CMD_ABORT_EN
  assign rx_abort = cmd.RX_VALID && cmd.RX_DATA[6] && (rx_count == 6'd0);
`else
  logic unused_abort_bit;
  assign unused_abort_bit = cmd.RX_DATA[6];
  assign rx_abort = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    done_q <= 1'b0;
    err_q  <= 1'b0;
    if (RST) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      remaining_q  <= '0;
      dir_q        <= 1'b0;
      stb_q        <= 1'b0;
      busy_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_dir_q   <= 1'b0;
      pend_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_cmd) begin
            state_q     <= HIGH;
            stb_q       <= 1'b1;
            busy_q      <= 1'b1;
            dir_q       <= cmd.RX_DATA[7];
            remaining_q <= rx_count;
            phase_q     <= '0;
          end
        end

        HIGH, LOW: begin
          if (rx_abort) begin
            state_q      <= IDLE;
            stb_q        <= 1'b0;
            busy_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            phase_q      <= '0;
          end else begin
            if (rx_cmd) begin
              if (!pend_valid_q) begin
                pend_valid_q <= 1'b1;
                pend_dir_q   <= cmd.RX_DATA[7];
                pend_count_q <= rx_count;
              end else begin
                err_q <= 1'b1;
              end
            end
            // Phase runs continuously across HIGH and LOW; it only wraps at the period end.
            if (state_q == HIGH) begin
              phase_q <= phase_q + 20'd1;
              if (phase_q == HIGH_LAST) begin
                state_q <= LOW;
                stb_q   <= 1'b0;
              end
            end else if (phase_q == PERIOD_LAST) begin
              phase_q     <= '0;
              remaining_q <= remaining_q - 6'd1;
              if (remaining_q == 6'd1) begin
                state_q <= FIN;
                done_q  <= 1'b1;
              end else begin
                state_q <= HIGH;
                stb_q   <= 1'b1;
              end
            end else begin
              phase_q <= phase_q + 20'd1;
            end
          end
        end

        FIN: begin
          if (rx_abort) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            pend_valid_q <= 1'b0;
          end else if (pend_valid_q) begin
            state_q      <= HIGH;
            stb_q        <= 1'b1;
            dir_q        <= pend_dir_q;
            remaining_q  <= pend_count_q;
            phase_q      <= '0;
            // The slot frees and refills in the same cycle, so no byte is lost here.
            pend_valid_q <= rx_cmd;
            if (rx_cmd) begin
              pend_dir_q   <= cmd.RX_DATA[7];
              pend_count_q <= rx_count;
            end
          end else if (rx_cmd) begin
            state_q     <= HIGH;
            stb_q       <= 1'b1;
            dir_q       <= cmd.RX_DATA[7];
            remaining_q <= rx_count;
            phase_q     <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd.STB  = stb_q;
  assign cmd.DIR  = dir_q;
  assign cmd.BUSY = busy_q;
  assign cmd.DONE = done_q;
  assign cmd.ERR  = err_q;

endmodule

// File: tb/tb_step_cmd_sequencer.sv
// Bench for step_cmd_sequencer: scenario table, hand-written corner sequences and random traffic,
// all cross-checked every cycle against a time-based reference model (honours CMD_ABORT_EN).
module tb_step_cmd_sequencer;
  localparam int D = 10;
  localparam int H = 5;

  logic clk;
  logic rst;
  step_cmd_if cmd_bus ();

  step_cmd_sequencer #(.STEP_DIV(D), .STB_HIGH(H)) dut (
    .CLK (clk),
    .RST (rst),
    .cmd (cmd_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Reference model: a burst is a start edge plus a step count; outputs follow from elapsed time.
  int         t_now;
  logic       m_active;
  int         m_s;
  int         m_n;
  logic       m_dir;
  logic       m_done;
  logic       m_err;
  logic [7:0] m_pend[$];

  // Event counters for the scenario table.
  int   pulse_cnt, done_cnt, err_cnt, busy_cnt;
  logic prev_stb;

  function automatic bit is_cmd(input logic v, input logic [7:0] d);
    return v && (d[5:0] != 6'd0);
  endfunction

  function automatic bit is_abort(input logic v, input logic [7:0] d);
`ifdef CMD_ABORT_EN
    return v && d[6] && (d[5:0] == 6'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_start(input logic [7:0] d);
    m_active = 1'b1;
    m_s      = t_now;
    m_n      = int'(d[5:0]);
    m_dir    = d[7];
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [7:0] d);
    int j;
    t_now  = t_now + 1;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_dir    = 1'b0;
      m_pend.delete();
    end else if (!m_active) begin
      if (is_cmd(v, d)) model_start(d);
    end else begin
      j = t_now - m_s;
      if (j <= m_n * D) begin
        if (is_abort(v, d)) begin
          m_active = 1'b0;
          m_pend.delete();
        end else begin
          if (is_cmd(v, d)) begin
            if (m_pend.size() == 0) m_pend.push_back(d);
            else m_err = 1'b1;
          end
          if (j == m_n * D) m_done = 1'b1;
        end
      end else begin
        if (is_abort(v, d)) begin
          m_active = 1'b0;
          m_pend.delete();
        end else if (m_pend.size() != 0) begin
          model_start(m_pend.pop_front());
          if (is_cmd(v, d)) m_pend.push_back(d);
        end else if (is_cmd(v, d)) begin
          model_start(d);
        end else begin
          m_active = 1'b0;
        end
      end
    end
  endtask

  function automatic logic [4:0] model_out();
    int   j;
    logic s;
    j = t_now - m_s;
    s = m_active && (j < m_n * D) && ((j % D) < H);
    return {s, m_dir, m_active, m_done, m_err};
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_cycle();
    logic [4:0] act;
    logic [4:0] exp;
    act = {cmd_bus.STB, cmd_bus.DIR, cmd_bus.BUSY, cmd_bus.DONE, cmd_bus.ERR};
    exp = model_out();
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL cycle %0d {stb,dir,busy,done,err}: got %b expected %b", t_now, act, exp);
    end
    if (cmd_bus.STB && !prev_stb) pulse_cnt++;
    if (cmd_bus.DONE) done_cnt++;
    if (cmd_bus.ERR) err_cnt++;
    if (cmd_bus.BUSY) busy_cnt++;
    prev_stb = cmd_bus.STB;
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    rst              = r;
    cmd_bus.RX_VALID = v;
    cmd_bus.RX_DATA  = d;
    @(posedge clk);
    model_edge(r, v, d);
    #1;
    check_cycle();
    rst              = 1'b0;
    cmd_bus.RX_VALID = 1'b0;
    cmd_bus.RX_DATA  = 8'h00;
  endtask

  task automatic clear_counts();
    pulse_cnt = 0;
    done_cnt  = 0;
    err_cnt   = 0;
    busy_cnt  = 0;
  endtask

  typedef struct {
    string      name;
    int         nb;
    logic [7:0] b0, b1, b2;
    int         t1, t2;
    int         exp_pulses, exp_done, exp_err, exp_busy;
    logic       exp_dir;
  } scen_t;

  scen_t scen[6];

  task automatic run_scen(input scen_t sc);
    logic       v;
    logic [7:0] d;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    clear_counts();
    for (int k = 0; k < 250; k++) begin
      v = 1'b0;
      d = 8'h00;
      if (k == 0) begin
        v = 1'b1; d = sc.b0;
      end else if (sc.nb > 1 && k == sc.t1) begin
        v = 1'b1; d = sc.b1;
      end else if (sc.nb > 2 && k == sc.t2) begin
        v = 1'b1; d = sc.b2;
      end
      step(1'b0, v, d);
    end
    check_int({sc.name, " pulses"}, pulse_cnt, sc.exp_pulses);
    check_int({sc.name, " done"}, done_cnt, sc.exp_done);
    check_int({sc.name, " err"}, err_cnt, sc.exp_err);
    check_int({sc.name, " busy"}, busy_cnt, sc.exp_busy);
    check_bit({sc.name, " dir"}, cmd_bus.DIR, sc.exp_dir);
  endtask

  initial begin
    logic       r, v;
    logic [7:0] d;
    n_checks = 0;
    n_errors = 0;
    t_now    = 0;
    m_active = 1'b0;
    m_s      = 0;
    m_n      = 0;
    m_dir    = 1'b0;
    m_done   = 1'b0;
    m_err    = 1'b0;
    prev_stb = 1'b0;
    clear_counts();
    rst              = 1'b1;
    cmd_bus.RX_VALID = 1'b0;
    cmd_bus.RX_DATA  = 8'h00;

    scen[0] = '{"single_0x83", 1, 8'h83, 8'h00, 8'h00, 0, 0, 3, 1, 0, 31, 1'b1};
    scen[1] = '{"queue_in_low", 2, 8'h02, 8'h81, 8'h00, 7, 0, 3, 2, 0, 32, 1'b1};
    scen[2] = '{"drop_third", 3, 8'h05, 8'h01, 8'h01, 3, 6, 6, 2, 1, 62, 1'b0};
    scen[3] = '{"zero_count", 1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1'b0};
`ifdef CMD_ABORT_EN
    scen[4] = '{"abort_third_high", 2, 8'h10, 8'h40, 8'h00, 22, 0, 3, 0, 0, 22, 1'b0};
    scen[5] = '{"abort_with_pend", 3, 8'h10, 8'h83, 8'h40, 3, 22, 3, 0, 0, 22, 1'b0};
`else
    scen[4] = '{"abort_third_high", 2, 8'h10, 8'h40, 8'h00, 22, 0, 16, 1, 0, 161, 1'b0};
    scen[5] = '{"abort_with_pend", 3, 8'h10, 8'h83, 8'h40, 3, 22, 19, 2, 0, 192, 1'b1};
`endif

    // Reset state
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check_bit("reset stb", cmd_bus.STB, 1'b0);
    check_bit("reset dir", cmd_bus.DIR, 1'b0);
    check_bit("reset busy", cmd_bus.BUSY, 1'b0);
    check_bit("reset done", cmd_bus.DONE, 1'b0);
    check_bit("reset err", cmd_bus.ERR, 1'b0);

    for (int i = 0; i < 6; i++) run_scen(scen[i]);

    // Latency, then a byte landing in FIN while pending is full.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h81);
    check_bit("latency stb", cmd_bus.STB, 1'b1);
    check_bit("latency busy", cmd_bus.BUSY, 1'b1);
    check_bit("latency dir", cmd_bus.DIR, 1'b1);
    for (int k = 1; k <= 10; k++) step(1'b0, (k == 3), (k == 3) ? 8'h02 : 8'h00);
    check_bit("fin done", cmd_bus.DONE, 1'b1);
    check_bit("fin stb", cmd_bus.STB, 1'b0);
    check_bit("fin busy", cmd_bus.BUSY, 1'b1);
    step(1'b0, 1'b1, 8'h83);
    check_bit("fin reload stb", cmd_bus.STB, 1'b1);
    check_bit("fin reload dir", cmd_bus.DIR, 1'b0);
    check_bit("fin refill err", cmd_bus.ERR, 1'b0);
    for (int k = 12; k <= 32; k++) step(1'b0, 1'b0, 8'h00);
    check_bit("refilled burst dir", cmd_bus.DIR, 1'b1);
    check_bit("refilled burst stb", cmd_bus.STB, 1'b1);
    for (int k = 0; k < 40; k++) step(1'b0, 1'b0, 8'h00);

    // Reset in the middle of a HIGH phase with a pending command.
    step(1'b0, 1'b1, 8'h84);
    for (int k = 1; k < 12; k++) step(1'b0, (k == 2), (k == 2) ? 8'h02 : 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check_bit("midreset stb", cmd_bus.STB, 1'b0);
    check_bit("midreset busy", cmd_bus.BUSY, 1'b0);
    clear_counts();
    for (int k = 0; k < 60; k++) step(1'b0, 1'b0, 8'h00);
    check_int("midreset pulses after", pulse_cnt, 0);
    step(1'b0, 1'b1, 8'h01);
    check_bit("restart stb", cmd_bus.STB, 1'b1);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 599) == 0);
      v = ($urandom_range(0, 11) == 0);
      d = 8'($urandom);
      if ($urandom_range(0, 3) != 0) d[5:0] = 6'($urandom_range(0, 4));
      step(r, v, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/step_cmd_sequencer.md
# step_cmd_sequencer

Command front-end for `moverMotor`: takes one-byte motion commands from the UART receive path and turns each into a burst of step strobes with a direction level. Its `STB` output drives `moverMotor.STB`. A one-deep pending slot lets the host queue the next command while the current burst runs. The block owns all step pacing, so `moverMotor` only ever sees clean, evenly spaced strobes.

## Interface
- `STEP_DIV`, 50000: clock cycles per step period (1 ms at 50 MHz); legal range 2..2^20.
- `STB_HIGH`, 25000: cycles `STB` is high within each period; 1 ≤ `STB_HIGH` < `STEP_DIV`.
- `CLK` input 1: single system clock, rising edge.
- `RST` input 1: synchronous, active-high reset.
- `RX_DATA` input 8: command byte from UART RX.
- `RX_VALID` input 1: one-cycle qualifier for `RX_DATA`.
- `STB` output 1: step strobe to `moverMotor`.
- `DIR` output 1: direction of the active burst (1 = forward).
- `BUSY` output 1: burst in progress.
- `DONE` output 1: one-cycle pulse when a burst completes normally.
- `ERR` output 1: one-cycle pulse when a command is dropped.

## Operation
- Command byte fields:
  - bit7 = direction.
  - bit6 = abort flag (see Configuration).
  - bits5:0 = step count N (0..63).
- Registers:
  - current {dir, remaining[5:0]}.
  - pending {valid, dir, count}.
  - phase counter, 20 bits, counting 0..`STEP_DIV`-1.
- States: IDLE, HIGH, LOW, FIN.
- IDLE:
  - `RX_VALID` with N≠0: load current, clear phase counter, go to HIGH.
  - N=0 with bit6=0: ignored, no `ERR`.
- HIGH:
  - `STB`=1.
  - At phase `STB_HIGH`-1, go to LOW.
- LOW:
  - `STB`=0.
  - At phase `STEP_DIV`-1, decrement remaining and clear phase.
  - If the new remaining is 0, go to FIN; otherwise go to HIGH.
- FIN:
  - `DONE`=1 for this cycle.
  - If pending is valid: load it into current, clear pending, go to HIGH.
  - Else if `RX_VALID` with N≠0: load that byte, go to HIGH.
  - Else go to IDLE.
- Byte arriving in HIGH or LOW:
  - Pending empty: store the byte in pending.
  - Pending full: drop the byte and pulse `ERR`.
- Byte arriving in FIN with pending full: pending moves to current, and the new byte is stored into pending in the same cycle. No `ERR`.
- `BUSY` = 1 in HIGH, LOW and FIN.
- `DIR` updates only when current is loaded, and is held for the whole burst and after it ends.

## Timing
- Reset values:
  - `STB`=0, `DIR`=0, `BUSY`=0, `DONE`=0, `ERR`=0.
  - Pending cleared, state IDLE, counters 0.
- Reset mid-burst: all outputs are at their reset values the cycle after `RST` is sampled high. The burst and any pending command are lost.
- Latency: `RX_VALID` in IDLE at edge n gives `STB`=1, `BUSY`=1 and the new `DIR` from cycle n+1.
- A burst of N steps occupies N·`STEP_DIV` cycles, followed by one FIN cycle.
- Back-to-back commands: exactly one FIN cycle (`STB`=0) between the last LOW of one burst and the first HIGH of the next.
- `ERR` and `DONE` are registered and asserted the cycle after the causing event.

## Configuration
- `CMD_ABORT_EN` defined:
  - A byte with bit6=1 and N=0 is an abort.
  - In HIGH, LOW or FIN: next cycle `STB`=0, state IDLE, pending cleared, no `DONE` pulse.
  - In IDLE: no effect.
  - An abort never pulses `ERR`, even when pending is full.
- `CMD_ABORT_EN` undefined:
  - bit6 is ignored.
  - N=0 bytes are always no-ops (no `ERR`).

## Test plan
All scenarios run with `STEP_DIV`=10, `STB_HIGH`=5.
- Byte 0x83 in IDLE → 3 `STB` pulses, each 5 cycles high within a 10-cycle period. `DIR`=1 from the next cycle. `BUSY` high for 31 cycles. `DONE` pulses once, in cycle 31.
- Byte 0x02, then byte 0x81 during the first LOW → 2 pulses with `DIR`=0, one FIN cycle, then 1 pulse with `DIR`=1. Two `DONE` pulses total, `ERR` never asserted.
- Bytes 0x05, 0x01, 0x01 sent within the first burst → third byte dropped with a 1-cycle `ERR` pulse. Exactly 6 `STB` pulses total.
- Byte 0x00 in IDLE → no `STB`, `BUSY` or `ERR` activity.
- With `CMD_ABORT_EN`: 0x10, then 0x40 during the third HIGH → `STB` low the next cycle, `BUSY`=0, no `DONE`, a queued pending command discarded. Without the macro, the same stimulus gives 16 pulses.
- `RST` asserted mid-HIGH with a pending command → `STB`/`BUSY`=0 the next cycle, and no further pulses until a new byte arrives.
